// File: rtl/mem_bus_pkg.sv
// Shared types and default sizes for the memory bus initiator.
package mem_bus_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_iobuf.sv
// Tristate pad for Mem_Bus: drives dout while drv_en is high, otherwise releases to Z.
// Combinational; din always reflects the resolved bus value.
module mem_bus_iobuf #(
  parameter int W = 32
) (
  input  logic         drv_en,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] bus
);

  assign bus = drv_en ? dout : {W{1'bz}};
  assign din = bus;

endmodule

// File: rtl/mem_bus_master.sv
// Single-request initiator on the shared CS/WE/ADDR/Mem_Bus memory bus (optional MEM_MASTER_RANGE_CHECK_EN).
// Latency: accept -> one ACCESS cycle -> response; one transaction per 3 cycles at best.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  state_t            state_q, state_n;
  logic              cs_q, cs_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              err_q, err_n;
  logic [DATA_W-1:0] bus_din;
  logic              bad_addr;

`ifdef MEM_MASTER_RANGE_CHECK_EN
  assign bad_addr = (req_addr >= ADDR_W'(DEPTH));
`else
  logic unused_range;
  assign unused_range = (req_addr >= ADDR_W'(DEPTH));
  assign bad_addr     = 1'b0;
`endif

  // we_q is only ever set for the ACCESS cycle, so the drive enable and WE
  // come from one flop and drop together; the memory never sees an overlap.
  mem_bus_iobuf #(.W(DATA_W)) u_iobuf (
    .drv_en (we_q),
    .dout   (wdata_q),
    .din    (bus_din),
    .bus    (Mem_Bus)
  );

  always_comb begin
    state_n = state_q;
    cs_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (bad_addr) begin
            state_n = RESP;
            err_n   = 1'b1;
            rdata_n = '0;
          end else begin
            state_n = ACCESS;
            cs_n    = 1'b1;
            we_n    = req_we;
            addr_n  = req_addr;
            wdata_n = req_wdata;
            err_n   = 1'b0;
          end
        end
      end
      ACCESS: begin
        state_n = RESP;
        rdata_n = we_q ? '0 : bus_din;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cs_q    <= cs_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign CS        = cs_q;
  assign WE        = we_q;
  assign ADDR      = addr_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: bus-level memory model plus transaction-level reference memory.
module tb_mem_bus_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 128;
  localparam int NRAND = 40;
`ifdef MEM_MASTER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, CS, WE;
  logic [AW-1:0] ADDR;
  wire  [DW-1:0] Mem_Bus;

  int total = 0;
  int bad = 0;

  mem_bus_master #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(Mem_Bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5A5_3C3C;
  endfunction

  // Memory attached to the bus: acts on the falling edge inside a CS cycle.
  logic [31:0] bus_mem [logic [31:0]];
  logic        mem_drv = 1'b0;
  logic [31:0] mem_dout = 32'h0;
  assign Mem_Bus = mem_drv ? mem_dout : {DW{1'bz}};

  always @(negedge CLK) begin
    if (CS && WE) bus_mem[ADDR] = Mem_Bus;
    mem_drv = CS && !WE;
    if (CS && !WE) mem_dout = bus_mem.exists(ADDR) ? bus_mem[ADDR] : init_word(ADDR);
  end

  always @(negedge RST_N) mem_drv = 1'b0;

  // Reference: what a load at each address should return.
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction already offered on the request port, DUT in IDLE.
  // With chain set, the next request is presented while this one is in flight.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input int stall, input bit chain,
                     input logic nwe, input logic [31:0] naddr, input logic [31:0] nwd);
    logic [31:0] exp_rd;
    bit          err;
    err = RC && (addr >= DEPTH);
    if (err || we) exp_rd = 32'h0;
    else exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr);
    if (!err && we) ref_mem[addr] = wd;

    chk("rdy_idle", req_ready, 1);
    rsp_ready = (stall == 0);
    @(posedge CLK); #1;
    if (chain) begin
      req_we = nwe; req_addr = naddr; req_wdata = nwd;
    end else begin
      req_valid = 1'b0;
    end
    if (!err) begin
      chk("cs_acc", CS, 1);
      chk("we_acc", WE, we);
      chk("addr_acc", ADDR, addr);
      chk("vld_acc", rsp_valid, 0);
      chk("rdy_acc", req_ready, 0);
      if (we) chk("bus_wr", Mem_Bus, wd);
      @(negedge CLK); #1;
      if (!we) chk("bus_rd", Mem_Bus, exp_rd);
      @(posedge CLK); #1;
    end
    chk("cs_resp", CS, 0);
    chk("we_resp", WE, 0);
    chk("vld_resp", rsp_valid, 1);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", rsp_err, err);
    chk("rdy_resp", req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK); #1;
      chk("vld_hold", rsp_valid, 1);
      chk("rdata_hold", rsp_rdata, exp_rd);
      chk("cs_hold", CS, 0);
      chk("rdy_hold", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("vld_done", rsp_valid, 0);
  endtask

  task automatic go(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int stall);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    txn(we, addr, wd, stall, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic        rw [NRAND];
  logic [31:0] ra [NRAND];
  logic [31:0] rd [NRAND];
  int          rs [NRAND];
  bit          rc [NRAND];

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_cs", CS, 0);
    chk("rst_we", WE, 0);
    chk("rst_addr", ADDR, 0);
    #10 RST_N = 1'b1;
    @(posedge CLK); #1;

    go(1'b1, 32'd5, 32'hDEAD_BEEF, 0);
    go(1'b0, 32'd5, 32'h0, 0);

    // Store then load at 7 with req_valid held across both.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h1234_5678;
    txn(1'b1, 32'd7, 32'h1234_5678, 0, 1'b1, 1'b0, 32'd7, 32'h0);
    txn(1'b0, 32'd7, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0);

    go(1'b0, 32'd5, 32'h0, 4);
    go(1'b0, 32'd200, 32'h0, 0);

    // Reset during a store's ACCESS cycle, before the memory's falling edge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'hCAFE_F00D;
    @(posedge CLK); #2;
    req_valid = 1'b0;
    chk("abort_cs_pre", CS, 1);
    RST_N = 1'b0;
    #1;
    chk("abort_cs", CS, 0);
    chk("abort_we", WE, 0);
    chk("abort_vld", rsp_valid, 0);
    chk("abort_rdy", req_ready, 1);
    @(negedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_rdy", req_ready, 1);
    chk("post_rst_rdata", rsp_rdata, 0);
    go(1'b0, 32'd9, 32'h0, 0);

    for (int i = 0; i < NRAND; i++) begin
      rw[i] = 1'($urandom_range(0, 1));
      ra[i] = ($urandom_range(0, 9) == 0) ? 32'(128 + $urandom_range(0, 300)) : 32'($urandom_range(0, 15));
      rd[i] = $urandom;
      rs[i] = int'($urandom_range(0, 3));
      rc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < NRAND; i++) begin
      int nx;
      nx = (i < NRAND - 1) ? i + 1 : i;
      if (i == 0 || !rc[i-1]) begin
        req_valid = 1'b1; req_we = rw[i]; req_addr = ra[i]; req_wdata = rd[i];
      end
      txn(rw[i], ra[i], rd[i], rs[i], rc[i] && (i < NRAND - 1), rw[nx], ra[nx], rd[nx]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator for the shared word-addressed memory bus (CS, WE, ADDR, bidirectional Mem_Bus): converts single load/store requests from the processor datapath into bus cycles against the 128-word memory and returns read data or write acknowledgement. It sits between the core's load/store stage and the memory, owns the bus-drive decision, and guarantees no drive overlap on Mem_Bus.

## Interface
Parameters:
- DATA_W, 32, width of Mem_Bus and request/response data
- ADDR_W, 32, width of ADDR and req_addr
- DEPTH, 128, number of words in the attached memory; used only by the range check

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block accepts a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  DATA_W  load data (0 for stores)
- rsp_err  output  1  address out of range (see Configuration)
- CS  output  1  memory chip select, active-high
- WE  output  1  memory write enable, active-high
- ADDR  output  ADDR_W  memory word address
- Mem_Bus  inout  DATA_W  shared data bus

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1, CS=0, WE=0, Mem_Bus released (Z). On req_valid: latch req_we/req_addr/req_wdata, go to ACCESS.
- ACCESS (exactly one cycle): CS=1, WE=latched we, ADDR=latched addr; Mem_Bus driven with latched wdata only when WE=1. At end of cycle: load captures Mem_Bus into rsp_rdata; store sets rsp_rdata=0. Go to RESP.
- RESP: CS=0, WE=0, bus released, rsp_valid=1, outputs stable until rsp_ready=1; then IDLE.
- CS, WE, ADDR and bus-drive enable are all registered from the same state flops: drive enable falls on the same edge as WE, so master and memory never drive Mem_Bus together.
- req_ready=1 only in IDLE; requests offered in ACCESS/RESP are not accepted and must be held by the requester.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, CS=0, WE=0, ADDR=0, Mem_Bus=Z, state IDLE.
- Reset asserted mid-ACCESS or mid-RESP: bus cycle aborted immediately (CS/WE low, bus released asynchronously); pending response discarded; a store in flight may or may not have committed.

## Timing
- Request accepted at rising edge T0 -> CS high T0..T1; memory acts on falling edge inside that cycle; rsp_valid rises at T1.
- Load latency: 1 cycle request-to-response; throughput with rsp_ready held 1: one access per 3 cycles (IDLE, ACCESS, RESP).
- rsp_rdata valid and constant for every cycle rsp_valid=1.
- ADDR holds last value outside ACCESS; only CS qualifies it.

## Configuration
- MEM_MASTER_RANGE_CHECK_EN defined: in IDLE, a request with req_addr >= DEPTH skips ACCESS (no CS pulse) and goes directly to RESP with rsp_err=1, rsp_rdata=0.
- Not defined: no check; every request runs a bus cycle with ADDR unchanged; rsp_err tied 0.

## Structure
- Package mem_bus_pkg: state enum (IDLE, ACCESS, RESP), DATA_W/ADDR_W/DEPTH default constants.
- One sub-module mem_bus_iobuf: tristate driver taking drive enable and output data, presenting Mem_Bus and sampled input data; all tristate logic lives there.

## Test plan
- Store req_addr=5, req_wdata=0xDEADBEEF -> one-cycle CS=1/WE=1 with Mem_Bus=0xDEADBEEF; rsp_valid next edge, rsp_err=0.
- Load addr 5 after the store -> CS=1/WE=0 one cycle, Mem_Bus not driven by master; rsp_rdata=0xDEADBEEF one cycle after accept.
- Back-to-back store addr 7 then load addr 7 with req_valid held -> second request accepted only after RESP; no cycle where master drive and memory drive overlap; load returns stored value.
- rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, CS=0 throughout.
- RST_N pulled low during ACCESS -> CS, WE, rsp_valid drop without waiting for CLK; Mem_Bus Z; after release req_ready=1.
- With MEM_MASTER_RANGE_CHECK_EN, load addr 200 -> no CS pulse, rsp_valid with rsp_err=1, rsp_rdata=0; without it, CS pulses and rsp_err=0.
